// File: rtl/ethernet_packet_parser.sv
// rtl/ethernet_packet_parser.sv - serial Ethernet frame receiver
// Recovers header, payload bytes and FCS from a one-bit-per-clock stream.
module ethernet_packet_parser #(
    parameter int MAX_LEN = 1500
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_packet,
    input  logic        i_packetValid,
    output logic [47:0] o_rxDMAC,
    output logic [47:0] o_rxSMAC,
    output logic [15:0] o_rxLength,
    output logic [31:0] o_rxFCS,
    output logic        o_hdrValid,
    output logic [7:0]  o_dout,
    output logic        o_doutValid,
    output logic        o_frameDone,
    output logic        o_frameError
);

    typedef enum logic [2:0] {
        S_DROP,
        S_IDLE,
        S_DMAC,
        S_SMAC,
        S_LEN,
        S_PAYLOAD,
        S_FCS,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [47:0] r_shift;
    logic [5:0]  r_bit_cnt;
    logic [15:0] r_byte_cnt;

    logic [47:0] w_shift_next;
    logic        w_len_bad;
    logic        w_len_zero;
    logic        w_last_byte;

    assign w_shift_next = {r_shift[46:0], i_packet};
    assign w_len_bad    = w_shift_next[15:0] > 16'(MAX_LEN);
    assign w_len_zero   = (w_shift_next[15:0] == 16'd0);
    assign w_last_byte  = ((r_byte_cnt + 16'd1) == o_rxLength);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_DROP;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            o_rxDMAC     <= '0;
            o_rxSMAC     <= '0;
            o_rxLength   <= '0;
            o_rxFCS      <= '0;
            o_hdrValid   <= 1'b0;
            o_dout       <= '0;
            o_doutValid  <= 1'b0;
            o_frameDone  <= 1'b0;
            o_frameError <= 1'b0;
        end else begin
            o_hdrValid   <= 1'b0;
            o_doutValid  <= 1'b0;
            o_frameDone  <= 1'b0;
            o_frameError <= 1'b0;

            unique case (r_state)
                S_DROP: begin
                    if (!i_packetValid) r_state <= S_IDLE;
                end

                S_IDLE: begin
                    if (i_packetValid) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= 6'd1;
                        r_state   <= S_DMAC;
                    end
                end

                S_GAP: begin
                    // A frame starting with no idle cycle cannot be delimited.
                    if (i_packetValid) begin
                        o_frameError <= 1'b1;
                        r_state      <= S_DROP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    if (!i_packetValid) begin
                        o_frameError <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        unique case (r_state)
                            S_DMAC: begin
                                if (r_bit_cnt == 6'd47) begin
                                    o_rxDMAC  <= w_shift_next;
                                    r_bit_cnt <= '0;
                                    r_state   <= S_SMAC;
                                end
                            end
                            S_SMAC: begin
                                if (r_bit_cnt == 6'd47) begin
                                    o_rxSMAC  <= w_shift_next;
                                    r_bit_cnt <= '0;
                                    r_state   <= S_LEN;
                                end
                            end
                            S_LEN: begin
                                if (r_bit_cnt == 6'd15) begin
                                    o_rxLength <= w_shift_next[15:0];
                                    r_bit_cnt  <= '0;
                                    r_byte_cnt <= '0;
                                    if (w_len_bad) begin
                                        o_frameError <= 1'b1;
                                        r_state      <= S_DROP;
                                    end else begin
                                        o_hdrValid <= 1'b1;
                                        r_state    <= w_len_zero ? S_FCS : S_PAYLOAD;
                                    end
                                end
                            end
                            S_PAYLOAD: begin
                                if (r_bit_cnt == 6'd7) begin
                                    o_dout      <= w_shift_next[7:0];
                                    o_doutValid <= 1'b1;
                                    r_bit_cnt   <= '0;
                                    r_byte_cnt  <= r_byte_cnt + 16'd1;
                                    if (w_last_byte) r_state <= S_FCS;
                                end
                            end
                            S_FCS: begin
                                if (r_bit_cnt == 6'd31) begin
                                    o_rxFCS     <= w_shift_next[31:0];
                                    o_frameDone <= 1'b1;
                                    r_bit_cnt   <= '0;
                                    r_state     <= S_GAP;
                                end
                            end
                            default: r_state <= S_DROP;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ethernet_packet_parser.md
# ethernet_packet_parser

Serial-to-parallel receive stage placed directly downstream of the Ethernet packet generator in `design_1`. It consumes the generator's one-bit `packet` stream qualified by `packetValid` and recovers the destination MAC, source MAC, length and FCS fields. It emits the payload as a byte stream and reports frame completion and framing errors. It performs no CRC computation; `rxFCS` carries the received field for checking further downstream.

## Interface
- `MAX_LEN`, 1500: largest accepted payload length in bytes. A larger `length` field is a framing error.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `packet`  in  1  serial frame bit from the generator.
- `packetValid`  in  1  qualifies `packet`; high for the whole frame.
- `rxDMAC`  out  48  destination MAC of the current/last frame.
- `rxSMAC`  out  48  source MAC.
- `rxLength`  out  16  length field.
- `rxFCS`  out  32  received FCS field.
- `hdrValid`  out  1  1-cycle pulse: `rxDMAC`, `rxSMAC` and `rxLength` are valid for the new frame.
- `dout`  out  8  payload byte.
- `doutValid`  out  1  1-cycle pulse per payload byte.
- `frameDone`  out  1  1-cycle pulse: frame complete, `rxFCS` valid.
- `frameError`  out  1  1-cycle pulse: frame aborted.

## Operation
- Wire format, fixed:
  - Field order: dMAC (6 B), sMAC (6 B), length (2 B), payload (`length` B), FCS (4 B). No preamble.
  - Each field is sent most-significant byte first. Each byte is sent MSB first.
  - One bit per clock while `packetValid`=1.
- Frame start: the first cycle `packetValid`=1 while in IDLE. The bit in that cycle is dMAC bit 47.
- States:
  - DROP (reset state): ignore input. Go to IDLE on the first cycle with `packetValid`=0.
  - IDLE: wait. On `packetValid`=1, shift the bit and go to DMAC.
  - DMAC: 48 bits total, counted from the start bit.
  - SMAC: 48 bits.
  - LEN: 16 bits. On completion:
    - if `length` > `MAX_LEN`: pulse `frameError` and go to DROP;
    - else pulse `hdrValid`, then go to PAYLOAD, or go straight to FCS if `length`=0.
  - PAYLOAD: shift 8 bits and emit a byte. Repeat until `length` bytes are emitted, using a 16-bit byte counter. Then go to FCS.
  - FCS: 32 bits. Latch `rxFCS`, pulse `frameDone`, go to GAP.
  - GAP: if `packetValid`=0, go to IDLE. If 1 (no inter-frame gap), pulse `frameError` and go to DROP.
- Truncation: `packetValid`=0 in DMAC/SMAC/LEN/PAYLOAD/FCS means:
  - pulse `frameError`, go to IDLE;
  - bytes already emitted are not retracted;
  - `frameDone` is not asserted.
- Field outputs:
  - update only on completion of their own field;
  - otherwise hold the previous frame's value.
- Exactly one of `frameDone`/`frameError` pulses per started frame, except on reset.
- Total frame length is 112 + 8·`length` + 32 bits.

## Timing
- Reset values:
  - all outputs 0, including `rxDMAC`/`rxSMAC`/`rxLength`/`rxFCS` and all pulses;
  - state DROP.
- Reset mid-frame:
  - immediate abort, no `frameError`;
  - the remainder of the frame is discarded by DROP.
- All outputs are registered.
  - `hdrValid` is high in the cycle after the 112th bit is sampled. Field registers are valid in that same cycle.
  - `doutValid` and `dout` are high/valid in the cycle after each byte's 8th bit is sampled.
  - `frameDone` and `rxFCS` are valid in the cycle after the last FCS bit is sampled.
  - `frameError` is high in the cycle after the offending sample.
- With `length`=0, `hdrValid` and the first FCS bit sample fall in the same cycle. `frameDone` follows 32 cycles later.
- The block applies no backpressure: there is no ready input, and `dout` is valid only in the `doutValid` cycle.

## Test plan
- Nominal frame: dMAC=A08CFD7E8FF3, sMAC=76DFBF883AA9, length=64, payload bytes 0..63, FCS=3157CB27; 656 bits, then `packetValid` low.
  - Required: `hdrValid` once, with exact field values.
  - Required: 64 `doutValid` pulses in order 0..63.
  - Required: `frameDone` one cycle after bit 656, with `rxFCS`=3157CB27; no `frameError`.
- Length 0 frame (144 bits):
  - Required: `hdrValid`, zero `doutValid`, `frameDone`, correct `rxFCS`.
- Truncation: length=64 frame with `packetValid` dropped after 300 bits.
  - Required: 23 bytes emitted, `frameError` one cycle later, no `frameDone`.
  - Required: a following valid frame parses correctly.
- Oversize: length=1501.
  - Required: `frameError` after bit 112, no `hdrValid`, no bytes.
  - Required: input ignored until `packetValid` falls; the next frame is fine.
- Back-to-back: second frame starts in the cycle right after the first frame's last FCS bit.
  - Required: first `frameDone`, then `frameError`, then second frame dropped.
- Reset:
  - Assert `reset` for 1 cycle at bit 200 of a frame. Required: all outputs 0, no error pulse, rest of the frame ignored, the next frame parses.
  - Start with `packetValid`=1 during reset. Required: no frame detected until `packetValid` has been low.
